// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants and FSM state type for the CAM write controller
package cam_pkg;
  localparam int CAM_ENTRIES = 32;
  localparam int CAM_IDX_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } cam_wctrl_state_t;
endpackage

// File: rtl/cam_free_finder.sv
// rtl/cam_free_finder.sv - lowest-index-zero priority encoder over the entry valid bitmap
module cam_free_finder
  import cam_pkg::*;
(
  input  logic [CAM_ENTRIES-1:0] bitmap,
  output logic [CAM_IDX_W-1:0]   free_idx,
  output logic                   any_free
);

  // Scan from the top down so the lowest clear bit is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = CAM_ENTRIES - 1; i >= 0; i--) begin
      if (!bitmap[i]) begin
        free_idx = CAM_IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_write_ctrl.sv
// rtl/cam_write_ctrl.sv - CAM write-side allocator and valid-bit tracker
// Optional round-robin eviction when full: define CAM_CTRL_EVICT_EN.
module cam_write_ctrl
  import cam_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = CAM_ENTRIES
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_req_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  output logic                 wr_ready_o,
  input  logic                 inv_req_i,
  input  logic [CAM_IDX_W-1:0] inv_index_i,
  output logic                 cam_write_enable_o,
  output logic [CAM_IDX_W-1:0] cam_write_index_o,
  output logic [DATA_W-1:0]    cam_write_data_o,
  output logic                 wr_done_o,
  output logic [ENTRIES-1:0]   valid_o,
  output logic [5:0]           count_o,
  output logic                 full_o,
  output logic                 evict_o
);

  cam_wctrl_state_t     state_q, state_d;
  logic                 alive_q;
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [CAM_IDX_W-1:0] idx_q, sel_idx, free_idx;
  logic [DATA_W-1:0]    data_q;
  logic                 any_free, accept_ok, accept;

  cam_free_finder u_free_finder (
    .bitmap   (valid_q),
    .free_idx (free_idx),
    .any_free (any_free)
  );

`ifdef CAM_CTRL_EVICT_EN
  logic [CAM_IDX_W-1:0] rr_ptr_q;
  logic                 evict_q;

  assign accept_ok = 1'b1;
  assign sel_idx   = any_free ? free_idx : rr_ptr_q;
  assign evict_o   = (state_q == ISSUE) && evict_q;

  // Pointer wraps naturally at 5 bits.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
      evict_q  <= 1'b0;
    end else begin
      if (accept) evict_q <= !any_free;
      if (state_q == ISSUE && evict_q) rr_ptr_q <= rr_ptr_q + 1'b1;
    end
  end
`else
  assign accept_ok = any_free;
  assign sel_idx   = free_idx;
  assign evict_o   = 1'b0;
`endif

  // alive_q holds ready low for the first cycle out of reset.
  assign wr_ready_o         = alive_q && (state_q == IDLE) && accept_ok;
  assign accept             = wr_req_i && wr_ready_o;
  assign cam_write_enable_o = (state_q == ISSUE);
  assign wr_done_o          = (state_q == ISSUE);
  assign cam_write_index_o  = idx_q;
  assign cam_write_data_o   = data_q;
  assign valid_o            = valid_q;
  assign count_o            = 6'($countones(valid_q));
  assign full_o             = (count_o == 6'd32);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write set is applied after the invalidate clear so a colliding write wins.
  always_comb begin
    valid_d = valid_q;
    if (inv_req_i) valid_d[inv_index_i] = 1'b0;
    if (state_q == ISSUE) valid_d[idx_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      valid_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      valid_q <= valid_d;
      if (accept) begin
        idx_q  <= sel_idx;
        data_q <= wr_data_i;
      end
    end
  end

endmodule
